// File: rtl/serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module   : serial_paralelo
// Brief    : Comma-aligned 1:8 deserializer; hunts 0xBC, syncs, strobes bytes.
// Revision : 1.0 - initial release
// ============================================================================
module serial_paralelo #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               SYNC_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             in_serial,
  output logic [WIDTH-1:0] out_paralelo,
  output logic             valid_out,
  output logic             active
);

  localparam int         c_CNT_W  = $clog2(WIDTH);
  localparam logic [1:0] c_HUNT    = 2'd0;
  localparam logic [1:0] c_ALIGNED = 2'd1;
  localparam logic [1:0] c_ACTIVE  = 2'd2;

  logic [1:0]         state_q,     state_d;
  logic [WIDTH-2:0]   shift_q;
  logic [c_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [3:0]         comma_cnt_q, comma_cnt_d;
  logic [WIDTH-1:0]   out_q,       out_d;
  logic               valid_q,     valid_d;
  logic               active_q,    active_d;

  logic [WIDTH-1:0]   cand;
  logic               is_comma;
  logic               last_bit;
  logic [3:0]         comma_inc;

  // cand is the byte whose LSB is being sampled at this edge
  assign cand      = {shift_q, in_serial};
  assign is_comma  = (cand == COMMA);
  assign last_bit  = (bit_cnt_q == c_CNT_W'(WIDTH - 1));
  assign comma_inc = comma_cnt_q + 4'd1;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= c_HUNT;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= cand[WIDTH-2:0];
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      c_HUNT: begin
        if (is_comma) begin
          comma_cnt_d = 4'd1;
          bit_cnt_d   = '0;
          state_d     = (SYNC_COUNT == 1) ? c_ACTIVE : c_ALIGNED;
        end
      end
      c_ALIGNED: begin
        bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        if (last_bit) begin
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            if (comma_inc == 4'(SYNC_COUNT)) begin
              state_d = c_ACTIVE;
            end
          end else begin
            comma_cnt_d = 4'd0;
            state_d     = c_HUNT;
          end
        end
      end
      c_ACTIVE: begin
        bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
      end
      default: begin
        state_d     = c_HUNT;
        bit_cnt_d   = '0;
        comma_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    out_d    = out_q;
    valid_d  = 1'b0;
    active_d = (state_d == c_ACTIVE);
    if ((state_q == c_ACTIVE) && last_bit && !is_comma) begin
      out_d   = cand;
      valid_d = 1'b1;
    end
  end

  assign out_paralelo = out_q;
  assign valid_out    = valid_q;
  assign active       = active_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_paralelo
// Brief    : Directed + random bitstreams against a queue-based receiver model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo;

  localparam int         SYNC  = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       in_serial = 1'b0;
  logic [7:0] out_paralelo;
  logic       valid_out;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0 = hunting, 1 = counting commas, 2 = synchronized
  int         m_mode   = 0;
  logic [7:0] m_hist   = '0;
  bit         m_bits[$];
  int         m_commas = 0;
  logic [7:0] m_out    = '0;
  logic       m_valid  = 1'b0;
  logic       m_active = 1'b0;

  serial_paralelo #(
    .WIDTH     (8),
    .COMMA     (COMMA),
    .SYNC_COUNT(SYNC)
  ) u_dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .in_serial   (in_serial),
    .out_paralelo(out_paralelo),
    .valid_out   (valid_out),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit b, input bit r);
    logic [7:0] byte_v;
    if (r) begin
      m_mode = 0; m_hist = '0; m_bits.delete(); m_commas = 0;
      m_out = '0; m_valid = 1'b0; m_active = 1'b0;
      return;
    end
    m_hist  = {m_hist[6:0], b};
    m_valid = 1'b0;
    if (m_mode == 0) begin
      if (m_hist == COMMA) begin
        m_commas = 1;
        m_bits.delete();
        m_mode = (SYNC == 1) ? 2 : 1;
      end
    end else begin
      m_bits.push_back(b);
      if (m_bits.size() == 8) begin
        byte_v = '0;
        foreach (m_bits[i]) byte_v = {byte_v[6:0], m_bits[i]};
        m_bits.delete();
        if (m_mode == 1) begin
          if (byte_v == COMMA) begin
            m_commas++;
            if (m_commas == SYNC) m_mode = 2;
          end else begin
            m_mode = 0;
            m_commas = 0;
          end
        end else if (byte_v != COMMA) begin
          m_out   = byte_v;
          m_valid = 1'b1;
        end
      end
    end
    m_active = (m_mode == 2);
  endtask

  task automatic cycle(input bit b, input bit r);
    @(negedge clk_32f);
    in_serial = b;
    reset     = r;
    @(posedge clk_32f);
    #1;
    model_step(b, r);
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("active", 32'(active), 32'(m_active));
    check("out_paralelo", 32'(out_paralelo), 32'(m_out));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) cycle(v[i], 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] rb;
    int         n;

    // idle after reset
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0);
    check("idle_active", 32'(active), 32'd0);

    // four commas bring the link up exactly at the last LSB
    for (int k = 0; k < 3; k++) send_byte(COMMA);
    for (int i = 7; i >= 1; i--) cycle(COMMA[i], 1'b0);
    check("pre_sync_active", 32'(active), 32'd0);
    cycle(COMMA[0], 1'b0);
    check("sync_active", 32'(active), 32'd1);

    // data, idle, data
    send_byte(8'hA5);
    check("a5_out", 32'(out_paralelo), 32'hA5);
    send_byte(COMMA);
    check("hold_out", 32'(out_paralelo), 32'hA5);
    send_byte(8'h3C);
    check("3c_out", 32'(out_paralelo), 32'h3C);
    cycle(1'b0, 1'b0);
    check("strobe_one_cycle", 32'(valid_out), 32'd0);

    // bit offset before commas
    do_reset();
    cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(COMMA);
    check("offset_active", 32'(active), 32'd1);
    send_byte(8'h55);
    check("offset_55", 32'(out_paralelo), 32'h55);

    // broken comma run restarts the count
    do_reset();
    for (int k = 0; k < 3; k++) send_byte(COMMA);
    send_byte(8'h11);
    check("broken_active", 32'(active), 32'd0);
    for (int k = 0; k < 3; k++) send_byte(COMMA);
    check("resync3_active", 32'(active), 32'd0);
    send_byte(COMMA);
    check("resync4_active", 32'(active), 32'd1);

    // reset mid-byte while synchronized
    send_byte(8'h77);
    rb = 8'h6E;
    for (int i = 7; i >= 5; i--) cycle(rb[i], 1'b0);
    cycle(rb[4], 1'b1);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_out", 32'(out_paralelo), 32'h00);
    for (int k = 0; k < 3; k++) send_byte(COMMA);
    check("midrst_3c", 32'(active), 32'd0);
    send_byte(COMMA);
    check("midrst_4c", 32'(active), 32'd1);

    // random mix of junk, comma runs, data and occasional resets
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) cycle(1'($urandom_range(0, 1)), 1'b0);
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) send_byte(COMMA);
      for (int k = 0; k < 3; k++) begin
        rb = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom);
        send_byte(rb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
